// File: rtl/morse_symbol_timer.sv
// morse_symbol_timer
// Turns a debounced key level into Morse timing events: classifies each
// press as dot or dash, packs up to five symbols into a letter code, and
// flags letter and word boundaries from the length of the release gap.
// All outputs come straight from registers; btn_press only reaches them
// through the edge detector and the FSM next-state logic.

module morse_symbol_timer #(
  parameter int TICK_DIV         = 1_000_000, // clock cycles per timing tick
  parameter int DASH_MIN_TICKS   = 20,        // press ticks at/above which a symbol is a dash
  parameter int LETTER_GAP_TICKS = 20,        // release ticks that close a letter
  parameter int WORD_GAP_TICKS   = 50,        // release ticks that close a word
  parameter int CNT_WIDTH        = 8          // duration counter width
) (
  input  logic       clk_100Mhz,
  input  logic       reset_n,
  input  logic       btn_press,
  output logic       sym_valid,
  output logic       sym_is_dash,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       word_end,
  output logic       busy
);

  // Prescaler width; TICK_DIV >= 2 keeps this at least one bit.
  localparam int PW = $clog2(TICK_DIV);

  // Longest letter the code register can hold.
  localparam logic [2:0] MAX_SYMS = 3'd5;

  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] DASH_TH    = CNT_WIDTH'(DASH_MIN_TICKS);
  localparam logic [CNT_WIDTH-1:0] LETTER_TH  = CNT_WIDTH'(LETTER_GAP_TICKS);
  localparam logic [CNT_WIDTH-1:0] WORD_TH    = CNT_WIDTH'(WORD_GAP_TICKS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,  // no letter pending
    S_PRESS     = 2'd1,  // key held, measuring press length
    S_GAP       = 2'd2,  // key released, letter still open
    S_WORD_WAIT = 2'd3   // letter closed, waiting for the word gap
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic                 r_btn_q;
  logic [PW-1:0]        r_presc;
  logic [CNT_WIDTH-1:0] r_cnt;

  state_t               r_state;
  logic [4:0]           r_acc_code;
  logic [2:0]           r_acc_len;
  logic                 r_acc_err;

  logic                 r_sym_valid;
  logic                 r_sym_is_dash;
  logic                 r_letter_valid;
  logic [4:0]           r_letter_code;
  logic [2:0]           r_letter_len;
  logic                 r_letter_err;
  logic                 r_word_end;
  logic                 r_busy;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_edge;
  logic                 w_tick;
  logic                 w_cnt_sat;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_is_dash;
  logic                 w_letter_reached;
  logic                 w_word_reached;

  state_t               w_state_next;
  logic [4:0]           w_acc_code_next;
  logic [2:0]           w_acc_len_next;
  logic                 w_acc_err_next;
  logic                 w_sym_valid_next;
  logic                 w_sym_is_dash_next;
  logic                 w_letter_valid_next;
  logic [4:0]           w_letter_code_next;
  logic [2:0]           w_letter_len_next;
  logic                 w_letter_err_next;
  logic                 w_word_end_next;
  logic                 w_busy_next;

  // Edge detection against the registered key level. btn_q powers up as
  // "pressed" so a key held across reset release cannot start a symbol.
  assign w_rise = btn_press & ~r_btn_q;
  assign w_fall = ~btn_press & r_btn_q;
  assign w_edge = w_rise | w_fall;

  // w_cnt_inc is the duration the counter would hold after this edge had
  // no key edge occurred. Using it (rather than r_cnt) makes a press of
  // exactly DASH_MIN_TICKS*TICK_DIV cycles count as a dash and lets the
  // gap thresholds fire exactly THRESHOLD*TICK_DIV cycles after the fall.
  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_cnt_sat = &r_cnt;
  assign w_cnt_inc = (w_tick && !w_cnt_sat) ? r_cnt + 1'b1 : r_cnt;

  assign w_is_dash        = (w_cnt_inc >= DASH_TH);
  assign w_letter_reached = (w_cnt_inc >= LETTER_TH);
  assign w_word_reached   = (w_cnt_inc >= WORD_TH);

  // Register the key level for edge detection.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q <= 1'b1;
    end else begin
      r_btn_q <= btn_press;
    end
  end

  // Tick prescaler and saturating duration counter, both restarted by any key edge.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_edge) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_cnt   <= w_cnt_inc;
    end
  end

  // FSM state, letter accumulators and registered outputs.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_acc_code     <= '0;
      r_acc_len      <= '0;
      r_acc_err      <= 1'b0;
      r_sym_valid    <= 1'b0;
      r_sym_is_dash  <= 1'b0;
      r_letter_valid <= 1'b0;
      r_letter_code  <= '0;
      r_letter_len   <= '0;
      r_letter_err   <= 1'b0;
      r_word_end     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_acc_code     <= w_acc_code_next;
      r_acc_len      <= w_acc_len_next;
      r_acc_err      <= w_acc_err_next;
      r_sym_valid    <= w_sym_valid_next;
      r_sym_is_dash  <= w_sym_is_dash_next;
      r_letter_valid <= w_letter_valid_next;
      r_letter_code  <= w_letter_code_next;
      r_letter_len   <= w_letter_len_next;
      r_letter_err   <= w_letter_err_next;
      r_word_end     <= w_word_end_next;
      r_busy         <= w_busy_next;
    end
  end

  // Next-state, accumulator and output logic; everything holds unless an event changes it.
  always_comb begin
    w_state_next        = r_state;
    w_acc_code_next     = r_acc_code;
    w_acc_len_next      = r_acc_len;
    w_acc_err_next      = r_acc_err;
    w_sym_valid_next    = 1'b0;
    w_sym_is_dash_next  = r_sym_is_dash;
    w_letter_valid_next = 1'b0;
    w_letter_code_next  = r_letter_code;
    w_letter_len_next   = r_letter_len;
    w_letter_err_next   = r_letter_err;
    w_word_end_next     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A stray fall (e.g. key held through reset) is ignored here.
        if (w_rise) begin
          w_state_next = S_PRESS;
        end
      end

      S_PRESS: begin
        if (w_fall) begin
          w_sym_valid_next   = 1'b1;
          w_sym_is_dash_next = w_is_dash;
          w_state_next       = S_GAP;
          if (r_acc_len < MAX_SYMS) begin
            w_acc_code_next = {r_acc_code[3:0], w_is_dash};
            w_acc_len_next  = r_acc_len + 3'd1;
          end else begin
            // Sixth and later symbols are dropped; the letter is flagged.
            w_acc_err_next = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (w_letter_reached) begin
          // Letter closes even if a new press starts on this very cycle;
          // that press then begins with empty accumulators.
          w_letter_valid_next = 1'b1;
          w_letter_code_next  = r_acc_code;
          w_letter_len_next   = r_acc_len;
          w_letter_err_next   = r_acc_err;
          w_acc_code_next     = '0;
          w_acc_len_next      = '0;
          w_acc_err_next      = 1'b0;
          w_state_next        = w_rise ? S_PRESS : S_WORD_WAIT;
        end else if (w_rise) begin
          // Short gap: next symbol of the same letter.
          w_state_next = S_PRESS;
        end
      end

      S_WORD_WAIT: begin
        // Counter keeps running from the original release.
        if (w_word_reached) begin
          w_word_end_next = 1'b1;
          w_state_next    = w_rise ? S_PRESS : S_IDLE;
        end else if (w_rise) begin
          w_state_next = S_PRESS;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Registered so busy tracks the state register without a decode path.
    w_busy_next = (w_state_next != S_IDLE);
  end

  assign sym_valid    = r_sym_valid;
  assign sym_is_dash  = r_sym_is_dash;
  assign letter_valid = r_letter_valid;
  assign letter_code  = r_letter_code;
  assign letter_len   = r_letter_len;
  assign letter_err   = r_letter_err;
  assign word_end     = r_word_end;
  assign busy         = r_busy;

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Directed testbench for morse_symbol_timer with a fast tick
// (TICK_DIV=4, dash >= 3 ticks, letter gap 3 ticks, word gap 7 ticks).
// Inputs change 1 time unit after the rising edge; pulse outputs are
// captured by a falling-edge monitor together with the edge index.

module tb_morse_symbol_timer;

  logic       clk_100Mhz = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_press  = 1'b1;
  logic       sym_valid;
  logic       sym_is_dash;
  logic       letter_valid;
  logic [4:0] letter_code;
  logic [2:0] letter_len;
  logic       letter_err;
  logic       word_end;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Rising-edge index and pulse monitor state.
  int cyc           = 0;
  int n_sym         = 0;
  int n_letter      = 0;
  int n_word        = 0;
  int n_long        = 0;
  int last_letter_cyc = -1;
  int last_word_cyc   = -1;
  logic prev_sym    = 1'b0;
  logic prev_letter = 1'b0;
  logic prev_word   = 1'b0;

  morse_symbol_timer #(
    .TICK_DIV        (4),
    .DASH_MIN_TICKS  (3),
    .LETTER_GAP_TICKS(3),
    .WORD_GAP_TICKS  (7),
    .CNT_WIDTH       (4)
  ) dut (
    .clk_100Mhz  (clk_100Mhz),
    .reset_n     (reset_n),
    .btn_press   (btn_press),
    .sym_valid   (sym_valid),
    .sym_is_dash (sym_is_dash),
    .letter_valid(letter_valid),
    .letter_code (letter_code),
    .letter_len  (letter_len),
    .letter_err  (letter_err),
    .word_end    (word_end),
    .busy        (busy)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  // Count pulses, remember which rising edge produced them, and flag any pulse wider than one cycle.
  always @(negedge clk_100Mhz) begin
    if (sym_valid) n_sym <= n_sym + 1;
    if (letter_valid) begin
      n_letter        <= n_letter + 1;
      last_letter_cyc <= cyc;
    end
    if (word_end) begin
      n_word        <= n_word + 1;
      last_word_cyc <= cyc;
    end
    if ((sym_valid && prev_sym) || (letter_valid && prev_letter) || (word_end && prev_word))
      n_long <= n_long + 1;
    prev_sym    <= sym_valid;
    prev_letter <= letter_valid;
    prev_word   <= word_end;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100Mhz);
      #1;
    end
  endtask

  // Hold the key for n cycles; p1 is the index of the edge that samples the fall.
  task automatic press(input int n, output int p1);
    btn_press = 1'b1;
    tick(n);
    btn_press = 1'b0;
    p1 = cyc + 1;
    $display("press %0d cycles, fall sampled at edge %0d", n, p1);
  endtask

  task automatic test_reset();
    int b_sym;
    int b_letter;
    reset_n   = 1'b0;
    btn_press = 1'b1;
    tick(3);
    n_cmp++;
    if ({sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_end, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_end, busy});
    end
    b_sym    = n_sym;
    b_letter = n_letter;
    reset_n  = 1'b1;
    tick(20);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_held_busy: got %b expected 0", busy); end
    btn_press = 1'b0;
    tick(10);
    n_cmp++;
    if (n_sym - b_sym !== 0) begin n_fail++; $display("FAIL reset_held_sym: got %0d pulses expected 0", n_sym - b_sym); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    n_cmp++;
    if (n_letter - b_letter !== 0) begin n_fail++; $display("FAIL reset_letter: got %0d pulses expected 0", n_letter - b_letter); end
    $display("reset test done");
  endtask

  task automatic test_dot_dash();
    int p1;
    int b_word;
    b_word = n_word;
    press(11, p1);
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL dot_sym_valid: got %b expected 1", sym_valid); end
    n_cmp++;
    if (sym_is_dash !== 1'b0) begin n_fail++; $display("FAIL dot_is_dash: got %b expected 0", sym_is_dash); end
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL dot_pulse_end: got %b expected 0", sym_valid); end
    tick(2);
    press(12, p1);
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL dash_sym_valid: got %b expected 1", sym_valid); end
    n_cmp++;
    if (sym_is_dash !== 1'b1) begin n_fail++; $display("FAIL dash_is_dash: got %b expected 1", sym_is_dash); end
    tick(40);
    n_cmp++;
    if (letter_code !== 5'b00001) begin n_fail++; $display("FAIL dd_code: got %b expected 00001", letter_code); end
    n_cmp++;
    if (letter_len !== 3'd2) begin n_fail++; $display("FAIL dd_len: got %0d expected 2", letter_len); end
    n_cmp++;
    if (n_word - b_word !== 1) begin n_fail++; $display("FAIL dd_word: got %0d pulses expected 1", n_word - b_word); end
  endtask

  task automatic test_letter();
    int p;
    int p1;
    int b_sym;
    int b_letter;
    int b_word;
    b_sym    = n_sym;
    b_letter = n_letter;
    b_word   = n_word;
    press(12, p); tick(4);
    press(4, p);  tick(4);
    press(12, p); tick(4);
    press(4, p1);
    tick(20);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL letter_busy_wait: got %b expected 1", busy); end
    n_cmp++;
    if (n_word - b_word !== 0) begin n_fail++; $display("FAIL letter_early_word: got %0d pulses expected 0", n_word - b_word); end
    tick(20);
    n_cmp++;
    if (n_sym - b_sym !== 4) begin n_fail++; $display("FAIL letter_syms: got %0d expected 4", n_sym - b_sym); end
    n_cmp++;
    if (n_letter - b_letter !== 1) begin n_fail++; $display("FAIL letter_count: got %0d expected 1", n_letter - b_letter); end
    n_cmp++;
    if (last_letter_cyc - p1 !== 12) begin n_fail++; $display("FAIL letter_timing: got %0d cycles expected 12", last_letter_cyc - p1); end
    n_cmp++;
    if (letter_code !== 5'b01010) begin n_fail++; $display("FAIL letter_code: got %b expected 01010", letter_code); end
    n_cmp++;
    if (letter_len !== 3'd4) begin n_fail++; $display("FAIL letter_len: got %0d expected 4", letter_len); end
    n_cmp++;
    if (letter_err !== 1'b0) begin n_fail++; $display("FAIL letter_err: got %b expected 0", letter_err); end
    n_cmp++;
    if (n_word - b_word !== 1) begin n_fail++; $display("FAIL word_count: got %0d expected 1", n_word - b_word); end
    n_cmp++;
    if (last_word_cyc - p1 !== 28) begin n_fail++; $display("FAIL word_timing: got %0d cycles expected 28", last_word_cyc - p1); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL word_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int p1;
    int b_sym;
    b_sym = n_sym;
    for (int i = 0; i < 6; i++) begin
      press(4, p1);
      if (i < 5) tick(4);
    end
    tick(40);
    n_cmp++;
    if (n_sym - b_sym !== 6) begin n_fail++; $display("FAIL ovf_syms: got %0d expected 6", n_sym - b_sym); end
    n_cmp++;
    if (letter_len !== 3'd5) begin n_fail++; $display("FAIL ovf_len: got %0d expected 5", letter_len); end
    n_cmp++;
    if (letter_code !== 5'b00000) begin n_fail++; $display("FAIL ovf_code: got %b expected 00000", letter_code); end
    n_cmp++;
    if (letter_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", letter_err); end
    n_cmp++;
    if (last_letter_cyc - p1 !== 12) begin n_fail++; $display("FAIL ovf_timing: got %0d cycles expected 12", last_letter_cyc - p1); end
  endtask

  task automatic test_back_to_back();
    int p;
    int p1;
    int p2;
    int b_letter;
    int b_word;
    // Press again after a letter gap but before the word gap.
    b_letter = n_letter;
    b_word   = n_word;
    press(4, p1);
    tick(20);
    n_cmp++;
    if (n_letter - b_letter !== 1) begin n_fail++; $display("FAIL b2b_first_letter: got %0d expected 1", n_letter - b_letter); end
    n_cmp++;
    if (last_letter_cyc - p1 !== 12) begin n_fail++; $display("FAIL b2b_first_timing: got %0d cycles expected 12", last_letter_cyc - p1); end
    press(12, p2);
    tick(40);
    n_cmp++;
    if (n_letter - b_letter !== 2) begin n_fail++; $display("FAIL b2b_letters: got %0d expected 2", n_letter - b_letter); end
    n_cmp++;
    if (n_word - b_word !== 1) begin n_fail++; $display("FAIL b2b_words: got %0d expected 1", n_word - b_word); end
    n_cmp++;
    if (letter_len !== 3'd1) begin n_fail++; $display("FAIL b2b_len: got %0d expected 1", letter_len); end
    n_cmp++;
    if (letter_code !== 5'b00001) begin n_fail++; $display("FAIL b2b_code: got %b expected 00001", letter_code); end

    // Rise sampled on exactly the edge that reaches the letter gap.
    b_letter = n_letter;
    b_word   = n_word;
    press(12, p);
    tick(4);
    press(4, p1);
    tick(12);
    press(4, p2);
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_is_dash !== 1'b0) begin n_fail++; $display("FAIL coin_sym: got valid=%b dash=%b expected valid=1 dash=0", sym_valid, sym_is_dash); end
    n_cmp++;
    if (n_letter - b_letter !== 1) begin n_fail++; $display("FAIL coin_letter: got %0d expected 1", n_letter - b_letter); end
    n_cmp++;
    if (last_letter_cyc - p1 !== 12) begin n_fail++; $display("FAIL coin_timing: got %0d cycles expected 12", last_letter_cyc - p1); end
    n_cmp++;
    if (letter_code !== 5'b00010 || letter_len !== 3'd2) begin n_fail++; $display("FAIL coin_first: got code=%b len=%0d expected code=00010 len=2", letter_code, letter_len); end
    n_cmp++;
    if (n_word - b_word !== 0) begin n_fail++; $display("FAIL coin_no_word: got %0d expected 0", n_word - b_word); end
    tick(40);
    n_cmp++;
    if (letter_code !== 5'b00000 || letter_len !== 3'd1 || letter_err !== 1'b0) begin n_fail++; $display("FAIL coin_second: got code=%b len=%0d err=%b expected code=00000 len=1 err=0", letter_code, letter_len, letter_err); end
    n_cmp++;
    if (n_word - b_word !== 1) begin n_fail++; $display("FAIL coin_word: got %0d expected 1", n_word - b_word); end
  endtask

  task automatic test_saturate_reset();
    int p1;
    int b_letter;
    int b_word;
    // 66 cycles is 16 ticks: a wrapping 4-bit counter would read 0.
    press(66, p1);
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_is_dash !== 1'b1) begin n_fail++; $display("FAIL sat66_dash: got valid=%b dash=%b expected 1 1", sym_valid, sym_is_dash); end
    tick(40);
    press(100, p1);
    tick(1);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_is_dash !== 1'b1) begin n_fail++; $display("FAIL sat100_dash: got valid=%b dash=%b expected 1 1", sym_valid, sym_is_dash); end
    tick(5);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got %b expected 1", busy); end
    b_letter = n_letter;
    b_word   = n_word;
    reset_n  = 1'b0;
    #1;
    n_cmp++;
    if ({sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_end, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0", {sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, letter_err, word_end, busy});
    end
    tick(2);
    reset_n = 1'b1;
    tick(40);
    n_cmp++;
    if (n_letter - b_letter !== 0) begin n_fail++; $display("FAIL reset_discard_letter: got %0d expected 0", n_letter - b_letter); end
    n_cmp++;
    if (n_word - b_word !== 0) begin n_fail++; $display("FAIL reset_discard_word: got %0d expected 0", n_word - b_word); end
    press(4, p1);
    tick(20);
    n_cmp++;
    if (letter_len !== 3'd1 || letter_code !== 5'b00000) begin n_fail++; $display("FAIL post_reset_letter: got len=%0d code=%b expected len=1 code=00000", letter_len, letter_code); end
  endtask

  task automatic test_pulse_width();
    n_cmp++;
    if (n_long !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d wide pulses expected 0", n_long); end
  endtask

  initial begin
    test_reset();
    test_dot_dash();
    test_letter();
    test_overflow();
    test_back_to_back();
    test_saturate_reset();
    tick(40);
    test_pulse_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
